// File: rtl/calc_pkg.sv
// calc_pkg: shared constants for the calculator input conditioning stage.
package calc_pkg;
  localparam int BTN_C = 0;
  localparam int BTN_L = 1;
  localparam int BTN_U = 2;
  localparam int BTN_R = 3;
  localparam int BTN_D = 4;
  localparam int N_BTN = 5;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 250000;
  localparam int SW_W = 16;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser, stable-level debouncer and press pulse for one button.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = calc_pkg::DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic pulse
);
  import calc_pkg::*;
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic s1_q, s2_q, lvl_q, lvl_d, pls_q, pls_d, hit;
  logic [CW-1:0] cnt_q, cnt_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      lvl_q <= 1'b0;
      cnt_q <= '0;
      pls_q <= 1'b0;
    end else begin
      s1_q  <= raw;
      s2_q  <= s1_q;
      lvl_q <= lvl_d;
      cnt_q <= cnt_d;
      pls_q <= pls_d;
    end
  end
  // hit: the synchronised input has disagreed with lvl for DEBOUNCE_CYCLES cycles
  always_comb begin
    hit   = (s2_q != lvl_q) && (cnt_q == LAST);
    cnt_d = (s2_q == lvl_q || hit) ? '0 : cnt_q + 1'b1;
    lvl_d = hit ? s2_q : lvl_q;
    pls_d = hit && s2_q;
  end
  assign level = lvl_q;
  assign pulse = pls_q;
endmodule

// File: rtl/calc_input_cond.sv
// calc_input_cond: debounces the pushbuttons into levels/press pulses and synchronises the switches.
module calc_input_cond #(
  parameter int N_BTN           = calc_pkg::N_BTN,
  parameter int DEBOUNCE_CYCLES = calc_pkg::DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_BTN-1:0]          btn_raw,
  input  logic [calc_pkg::SW_W-1:0] sw_raw,
  output logic [N_BTN-1:0]          btn_level,
  output logic [N_BTN-1:0]          btn_pulse,
  output logic [calc_pkg::SW_W-1:0] sw_sync
);
  import calc_pkg::*;
  logic [SW_W-1:0] sw_s1_q, sw_s2_q;
  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk  (clk),
      .rst  (rst),
      .raw  (btn_raw[g]),
      .level(btn_level[g]),
      .pulse(btn_pulse[g])
    );
  end
  // switches are levels read by the datapath, so synchronising is enough
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
    end else begin
      sw_s1_q <= sw_raw;
      sw_s2_q <= sw_s1_q;
    end
  end
  assign sw_sync = sw_s2_q;
endmodule

// File: tb/tb_calc_input_cond.sv
// tb_calc_input_cond: directed stimulus with a queued expectation scoreboard and per-cycle pulse monitor.
module tb_calc_input_cond;
  import calc_pkg::*;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] btn_raw;
  logic [15:0] sw_raw;
  logic [4:0] btn_level, btn_pulse;
  logic [15:0] sw_sync;
  int cyc = 0;
  int checks = 0;
  int passes = 0;
  typedef struct {
    int c;
    logic [4:0] lvl;
    logic [15:0] sw;
    string name;
  } exp_t;
  exp_t q[$];
  logic [4:0] exp_pulse [int];

  calc_input_cond #(.N_BTN(5), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .sw_raw(sw_raw),
    .btn_level(btn_level), .btn_pulse(btn_pulse), .sw_sync(sw_sync)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, want);
    else passes++;
  endtask

  task automatic push_exp(input int c, input logic [4:0] lvl, input logic [15:0] sw, input string name);
    exp_t e;
    e.c = c; e.lvl = lvl; e.sw = sw; e.name = name;
    q.push_back(e);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    chk("pulse", 32'(btn_pulse), 32'(exp_pulse.exists(cyc) ? exp_pulse[cyc] : 5'b0));
    while (q.size() > 0 && q[0].c <= cyc) begin
      e = q.pop_front();
      chk({e.name, "_lvl"}, 32'(btn_level), 32'(e.lvl));
      chk({e.name, "_sw"}, 32'(sw_sync), 32'(e.sw));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, h, p, r, s, m, w;
    rst = 1'b1; btn_raw = '1; sw_raw = '1;
    repeat (3) @(negedge clk);
    push_exp(cyc + 1, 5'b0, 16'h0, "reset");
    @(negedge clk);
    c = cyc; rst = 1'b0; btn_raw = 5'b00001; sw_raw = '0;
    exp_pulse[c + 6] = 5'b00001;
    push_exp(c + 5, 5'b00000, 16'h0, "t1_pre");
    push_exp(c + 6, 5'b00001, 16'h0, "t1_rise");
    wait_to(c + 12);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      btn_raw[BTN_D] = (k % 4 != 3);
      if (k % 4 == 3) push_exp(cyc + 1, 5'b00001, 16'h0, "t2_bounce");
    end
    @(negedge clk);
    h = cyc; btn_raw[BTN_D] = 1'b1;
    exp_pulse[h + 6] = 5'b10000;
    push_exp(h + 5, 5'b00001, 16'h0, "t2_pre");
    push_exp(h + 6, 5'b10001, 16'h0, "t2_rise");
    wait_to(h + 10);
    p = cyc; btn_raw[BTN_R] = 1'b1;
    exp_pulse[p + 6] = 5'b01000;
    push_exp(p + 6, 5'b11001, 16'h0, "t3_press");
    wait_to(p + 20);
    btn_raw[BTN_R] = 1'b0;
    push_exp(p + 25, 5'b11001, 16'h0, "t3_hold");
    push_exp(p + 26, 5'b10001, 16'h0, "t3_release");
    wait_to(p + 30);
    r = cyc; btn_raw = '0;
    push_exp(r + 5, 5'b10001, 16'h0, "rel_pre");
    push_exp(r + 6, 5'b00000, 16'h0, "rel_all");
    wait_to(r + 10);
    s = cyc; btn_raw = 5'b10101;
    exp_pulse[s + 6] = 5'b10101;
    push_exp(s + 5, 5'b00000, 16'h0, "t4_pre");
    push_exp(s + 6, 5'b10101, 16'h0, "t4_rise");
    wait_to(s + 10);
    btn_raw = '0;
    push_exp(s + 16, 5'b00000, 16'h0, "t4_release");
    wait_to(s + 20);
    m = cyc; btn_raw[BTN_L] = 1'b1;
    wait_to(m + 4);
    rst = 1'b1;
    push_exp(m + 5, 5'b00000, 16'h0, "t5_in_rst");
    wait_to(m + 6);
    rst = 1'b0;
    exp_pulse[m + 12] = 5'b00010;
    push_exp(m + 11, 5'b00000, 16'h0, "t5_pre");
    push_exp(m + 12, 5'b00010, 16'h0, "t5_rise");
    wait_to(m + 16);
    btn_raw = '0;
    push_exp(m + 21, 5'b00010, 16'h0, "t5_hold");
    push_exp(m + 22, 5'b00000, 16'h0, "t5_release");
    wait_to(m + 26);
    w = cyc; sw_raw = 16'hA5C3;
    push_exp(w + 1, 5'b00000, 16'h0000, "t6_one");
    push_exp(w + 2, 5'b00000, 16'hA5C3, "t6_two");
    wait_to(w + 6);
    chk("leftover", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/calc_input_cond.md
# calc_input_cond

Input conditioning stage that sits directly upstream of the calculator datapath. It takes the five raw pushbuttons and the 16 raw slide switches from the board, synchronises them into the `clk` domain, and debounces every button. Each button press produces exactly one single-cycle pulse. The calculator's accumulator-update and clear inputs are driven from these clean pulses and levels, never from the raw pins.

## Interface

Parameters:
- `N_BTN`, default 5: number of buttons.
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable synchronised cycles required to accept a level change. Legal range is ≥ 2.

Ports:
- `clk`  in  1: system clock. Everything is on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `btn_raw`  in  `N_BTN`: raw buttons, index 0 btnc, 1 btnl, 2 btnu, 3 btnr, 4 btnd.
- `sw_raw`  in  16: raw switches.
- `btn_level`  out  `N_BTN`: debounced button levels.
- `btn_pulse`  out  `N_BTN`: one-cycle pulse on each debounced 0→1 transition.
- `sw_sync`  out  16: synchronised switches.

## Operation

- **Reset.** While `rst` is high, all of the following are forced to 0 and held asynchronously:
  - synchroniser flops;
  - debounce counters;
  - `btn_level`, `btn_pulse`, `sw_sync`.
- **Synchroniser.** Each button and switch bit passes through 2 flops: `s1` then `s2`.
- **Per-button debounce.**
  - State: stable level `lvl` (which drives `btn_level`) and counter `cnt`, width clog2(`DEBOUNCE_CYCLES`).
  - If `s2 == lvl`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `lvl <= s2`, `cnt <= 0`.
  - Else: `cnt <= cnt+1`.
- **Pulse.** `btn_pulse[i] <= (s2==1 && lvl==0 && cnt==DEBOUNCE_CYCLES-1)`. It rises in the same cycle that `btn_level[i]` rises and is high for exactly 1 cycle.
- **Release.** Release is debounced symmetrically. No pulse is generated on a 1→0 transition.
- **Glitches.** A synchronised excursion shorter than `DEBOUNCE_CYCLES` cycles resets `cnt` when it ends and produces no level change and no pulse. This holds however many glitches occur.
- **Independence.**
  - Buttons are fully independent. Simultaneous presses give simultaneous pulses.
  - A held button never re-pulses.
- **Switches.** Switches are synchronised only, with no debounce. `sw_sync = s2`.

## Timing

- **Button latency.** Let edge 0 be the first rising edge that samples `btn_raw[i]`=1, with the input held steady from then on.
  - `btn_level[i]` and `btn_pulse[i]` become 1 after edge `DEBOUNCE_CYCLES+1`.
  - `btn_pulse[i]` returns to 0 after edge `DEBOUNCE_CYCLES+2`.
- **Release latency.** Release has the same latency, `DEBOUNCE_CYCLES+1` edges.
- **Switch latency.** `sw_sync` follows `sw_raw` after 2 edges.
- **Reset mid-count.** All counting is lost. If a button is still held when `rst` falls, the first post-reset edge is edge 0. A pulse then follows after `DEBOUNCE_CYCLES+1` edges, because the press is re-accepted.
- **Reset mid-pulse.** `btn_pulse` drops to 0 immediately and asynchronously. No residual pulse appears after reset.
- **Consumer guarantee.** Pulses of the same button are separated by at least 2·`DEBOUNCE_CYCLES` cycles.

## Structure

- **Shared package `calc_pkg`:**
  - button index constants `BTN_C=0`, `BTN_L=1`, `BTN_U=2`, `BTN_R=3`, `BTN_D=4`;
  - `N_BTN`;
  - default `DEBOUNCE_CYCLES`;
  - `SW_W=16`.
- **Sub-module `btn_debounce`.** One button: synchroniser, counter, level and pulse. It takes parameter `DEBOUNCE_CYCLES` and ports `clk`, `rst`, `raw`, `level`, `pulse`.
- **Top level.** Generates `N_BTN` instances of `btn_debounce` and contains the 16-bit 2-flop switch synchroniser.
- **Simulation value.** Benches use `DEBOUNCE_CYCLES`=4.

## Test plan

1. **Reset.** Assert `rst` with all inputs 1; `btn_level`, `btn_pulse` and `sw_sync` are 0. Release `rst`, hold `btn_raw`=5'b00001.
   - Required: `btn_level[0]` and `btn_pulse[0]` go high after edge 5 (D=4).
   - Required: `btn_pulse[0]` is low after edge 6.
2. **Bounce.**
   - Drive `btn_raw[4]` as 1,1,1,0 repeated for 40 cycles: `btn_level`=0 and `btn_pulse`=0 throughout.
   - Then hold it at 1: exactly 1 pulse, 5 edges after the hold starts.
3. **Press and release.** Press `btn_raw[3]` for 20 cycles, then release.
   - Required: one pulse on press.
   - Required: `btn_level[3]` falls 5 edges after release.
   - Required: no pulse on release.
4. **Simultaneous presses.** `btn_raw`=5'b10101 on the same edge: `btn_pulse`=5'b10101 for 1 cycle, with no other pulses.
5. **Reset mid-count.** Hold `btn_raw[1]`=1, then assert `rst` after edge 3 for 2 cycles.
   - Required: no pulse before or during reset.
   - Required: a pulse after edge 5 counted from `rst` deassertion.
6. **Switches.** Drive `sw_raw`=16'hA5C3: `sw_sync`=16'hA5C3 after 2 edges, and no button outputs change.
